// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared constants for the bit-serial adder/subtractor controller.
// Contents:
//   ST_IDLE, ST_SHIFT, ST_DONE : FSM state encodings (2-bit, legacy-compatible)
//   MODE_ADD, MODE_SUB         : operation select values for the mode input
package serial_addsub_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bus between a requester and the bit-serial add/sub controller.
// Signals:
//   start    requester -> ctrl  request, looked at only while the controller is idle
//   mode     requester -> ctrl  0 = add, 1 = subtract (A-B)
//   a, b     requester -> ctrl  operands, WIDTH bits
//   busy     ctrl -> requester  high while bits are being processed
//   done     ctrl -> requester  one-cycle pulse, result/cout/overflow valid
//   result   ctrl -> requester  sum or difference, held until the next operation ends
//   cout     ctrl -> requester  final carry (subtract: 1 = no borrow)
//   overflow ctrl -> requester  signed overflow flag
// Modports: master = requester side, slave = controller side.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
) ();
    import serial_addsub_ctrl_pkg::*;

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, cout, overflow
    );

endinterface

// File: rtl/serial_addsub_ctrl_fa.sv
// 1-bit full-adder cell shared by the serial controller.
// Ports:
//   a, b, cin  in   operand bits and carry in
//   sum        out  a ^ b ^ cin
//   carry      out  majority(a, b, cin)
module serial_addsub_ctrl_fa
    import serial_addsub_ctrl_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor controller. One shared full-adder cell is stepped
// over WIDTH cycles, LSB first, to form A+B or A-B (two's complement, A + ~B + 1).
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset; aborts any operation, no done pulse
//   bus   slave side of serial_addsub_ctrl_if (start/mode/a/b in,
//         busy/done/result/cout/overflow out, all outputs registered)
// Timing: start accepted at edge N -> done high in the cycle after edge N+WIDTH+1;
// start-to-start throughput is WIDTH+2 cycles.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             cmsb;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    serial_addsub_ctrl_fa u_fa (
        .a     (op_a[0]),
        .b     (op_b[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_a         <= '0;
            op_b         <= '0;
            sum_sr       <= '0;
            carry        <= 1'b0;
            cmsb         <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_a     <= bus.a;
                        // Subtraction: invert B here and seed the carry with 1.
                        op_b     <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                        carry    <= bus.mode;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Sum bits enter from the MSB side so the LSB ends at bit 0.
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    carry  <= fa_carry;
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // Carry entering the MSB position, needed for signed overflow.
                        cmsb     <= carry;
                        bus.busy <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.result   <= sum_sr;
                    bus.cout     <= carry;
                    bus.overflow <= cmsb ^ carry;
                    bus.done     <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    // Illegal encodings recover to idle, never to DONE.
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8): directed cases, abort
// by reset, back-to-back throughput and a randomized sweep against a reference
// built from plain integer arithmetic.
module tb_serial_addsub_ctrl;

    localparam int W = 8;
    localparam int P = W + 2;

    logic clk;
    logic rst;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, cout, result} from integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic m);
        int ux, uy, sx, sy, us, ss;
        logic c, v;
        logic [W-1:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m) begin
            us = ux - uy;
            ss = sx - sy;
            c  = (ux >= uy);
        end else begin
            us = ux + uy;
            ss = sx + sy;
            c  = (us >= (1 << W));
        end
        r = W'(us);
        v = (ss > ((1 << (W - 1)) - 1)) || (ss < -(1 << (W - 1)));
        return {v, c, r};
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, " result"}, 32'(bus.result), 32'(exp_res));
        chk({tag, " cout"}, 32'(bus.cout), 32'(exp_cout));
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    endtask

    // One operation; glitch_j >= 0 pulses start at that sample point (0..W keeps
    // it inside SHIFT or DONE) with scrambled operands, which must be ignored.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic md, input int glitch_j);
        logic [W+1:0] r;
        r = ref_op(av, bv, md);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = md;
        bus.a     = av;
        bus.b     = bv;
        for (int j = 0; j <= W + 2; j++) begin
            @(negedge clk);
            bus.start = (j == glitch_j);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.mode  = 1'($urandom_range(0, 1));
            chk({tag, " busy"}, 32'(bus.busy), 32'(j < W));
            chk({tag, " done"}, 32'(bus.done), 32'(j == W + 1));
            if (j == W + 1) begin
                exp_res  = r[W-1:0];
                exp_cout = r[W];
                exp_ovf  = r[W+1];
            end
            if (j == W || j == W + 1) chk_outputs(tag);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int dpos[$];
        logic [W+1:0] r;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        exp_res   = '0;
        exp_cout  = 1'b0;
        exp_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk_outputs("reset");
        rst = 1'b0;

        run_op("add3c45", 8'h3C, 8'h45, 1'b0, -1);
        chk("add3c45 const res", 32'(bus.result), 32'h81);
        chk("add3c45 const ovf", 32'(bus.overflow), 32'd1);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, -1);
        chk("addff01 const res", 32'(bus.result), 32'h00);
        chk("addff01 const cout", 32'(bus.cout), 32'd1);
        run_op("sub1001", 8'h10, 8'h01, 1'b1, W);
        chk("sub1001 const res", 32'(bus.result), 32'h0F);
        chk("sub1001 const cout", 32'(bus.cout), 32'd1);
        run_op("sub0001", 8'h00, 8'h01, 1'b1, -1);
        chk("sub0001 const res", 32'(bus.result), 32'hFF);
        chk("sub0001 const cout", 32'(bus.cout), 32'd0);
        chk("sub0001 const ovf", 32'(bus.overflow), 32'd0);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 3);
        chk("sub8001 const res", 32'(bus.result), 32'h7F);
        chk("sub8001 const ovf", 32'(bus.overflow), 32'd1);

        // Abort by reset after three bits have been processed.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h33;
        bus.mode  = 1'b0;
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("abort busy pre", 32'(bus.busy), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_res  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk_outputs("abort");
        for (int j = 0; j < P + 2; j++) begin
            @(negedge clk);
            chk("abort no done", 32'(bus.done), 32'd0);
            chk("abort idle busy", 32'(bus.busy), 32'd0);
        end
        run_op("post-abort", 8'h5A, 8'h33, 1'b0, -1);

        // Start held high: accepted again right after each DONE.
        r = ref_op(8'hC7, 8'h2E, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hC7;
        bus.b     = 8'h2E;
        bus.mode  = 1'b1;
        for (int j = 0; j < 3 * P; j++) begin
            @(negedge clk);
            if (j == 3 * P - 1) bus.start = 1'b0;
            chk("b2b busy", 32'(bus.busy), 32'((j % P) < W));
            chk("b2b done", 32'(bus.done), 32'((j % P) == W + 1));
            if (bus.done) begin
                dpos.push_back(j);
                exp_res  = r[W-1:0];
                exp_cout = r[W];
                exp_ovf  = r[W+1];
                chk_outputs("b2b");
            end
        end
        chk("b2b pulse count", 32'(dpos.size()), 32'd3);
        if (dpos.size() >= 2) chk("b2b spacing", 32'(dpos[1] - dpos[0]), 32'(P));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("b2b idle busy", 32'(bus.busy), 32'd0);
        end

        // Randomized sweep, some with ignored start pulses mid-operation.
        for (int i = 0; i < 1000; i++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
